// File: rtl/blackjack_table_if.sv
// rtl/blackjack_table_if.sv - card stream between card source and blackjack table
interface blackjack_table_if;
    logic [4:0] card;
    logic       card_valid;
    logic       card_req;

    modport master (output card, output card_valid, input card_req);
    modport slave  (input card, input card_valid, output card_req);
endinterface

// File: rtl/blackjack_table.sv
// rtl/blackjack_table.sv - one-round blackjack controller pulling cards from a request/valid stream
module blackjack_table (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     hit,
    input  logic                     stay,
    blackjack_table_if.slave         cif,
    output logic [4:0]               player_total,
    output logic [4:0]               dealer_total,
    output logic                     player_soft,
    output logic                     dealer_soft,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               result
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2,
        S_PLAYER, S_P_DRAW, S_DEALER, S_D_DRAW, S_RESOLVE, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] p_hard, d_hard;
    logic       p_ace, d_ace;
    logic [1:0] result_q;

    logic       req, card_ok, take, to_player, idle_like;
    logic       p_soft_w, d_soft_w;
    logic [4:0] p_best, d_best, p_sum;

    // An ace counts as 11 only while that keeps the hand at or under 21.
    always_comb begin
        p_soft_w  = p_ace && (p_hard <= 5'd11);
        d_soft_w  = d_ace && (d_hard <= 5'd11);
        p_best    = p_soft_w ? p_hard + 5'd10 : p_hard;
        d_best    = d_soft_w ? d_hard + 5'd10 : d_hard;
        req       = state inside {S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_P_DRAW, S_D_DRAW};
        to_player = state inside {S_DEAL_P1, S_DEAL_P2, S_P_DRAW};
        idle_like = (state == S_IDLE) || (state == S_DONE);
        card_ok   = (cif.card >= 5'd1) && (cif.card <= 5'd10);
        take      = req && cif.card_valid && card_ok;
        p_sum     = p_hard + cif.card;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_DEAL_P1;
            S_DEAL_P1:      if (take) state_nxt = S_DEAL_D1;
            S_DEAL_D1:      if (take) state_nxt = S_DEAL_P2;
            S_DEAL_P2:      if (take) state_nxt = S_DEAL_D2;
            S_DEAL_D2:      if (take) state_nxt = S_PLAYER;
            S_PLAYER: begin
                if (p_best == 5'd21 || stay) state_nxt = S_DEALER;
                else if (hit)                state_nxt = S_P_DRAW;
            end
            S_P_DRAW:       if (take) state_nxt = (p_sum > 5'd21) ? S_RESOLVE : S_PLAYER;
            S_DEALER:       state_nxt = (d_best < 5'd17) ? S_D_DRAW : S_RESOLVE;
            S_D_DRAW:       if (take) state_nxt = S_DEALER;
            S_RESOLVE:      state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_hard   <= 5'd0;
            d_hard   <= 5'd0;
            p_ace    <= 1'b0;
            d_ace    <= 1'b0;
            result_q <= 2'b00;
        end else if (idle_like && start) begin
            p_hard   <= 5'd0;
            d_hard   <= 5'd0;
            p_ace    <= 1'b0;
            d_ace    <= 1'b0;
            result_q <= 2'b00;
        end else if (take) begin
            if (to_player) begin
                p_hard <= p_sum;
                p_ace  <= p_ace | (cif.card == 5'd1);
            end else begin
                d_hard <= d_hard + cif.card;
                d_ace  <= d_ace | (cif.card == 5'd1);
            end
        end else if (state == S_RESOLVE) begin
            if (p_hard > 5'd21)       result_q <= 2'b10;
            else if (d_hard > 5'd21)  result_q <= 2'b01;
            else if (p_best > d_best) result_q <= 2'b01;
            else if (p_best < d_best) result_q <= 2'b10;
            else                      result_q <= 2'b11;
        end
    end

    assign cif.card_req  = req;
    assign player_total  = p_best;
    assign dealer_total  = d_best;
    assign player_soft   = p_soft_w;
    assign dealer_soft   = d_soft_w;
    assign busy          = !idle_like;
    assign done          = (state == S_DONE);
    assign result        = result_q;

endmodule
